// File: rtl/updown_mod_counter_pkg.sv
// Shared constants and an elaboration-time sizing helper for the up/down modulo counter family.
// Holds no logic, so it adds no latency and has no flow control.
package counter_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DN    = 1'b0;
    localparam int   MODE_WRAP = 0;
    localparam int   MODE_SAT  = 1;

    // Number of bits needed to hold the values 0..v-1.
    function automatic int cnt_clog2(input longint unsigned v);
        for (int i = 0; i < 64; i++) begin
            if ((64'd1 << i) >= v) return i;
        end
        return 64;
    endfunction

endpackage

// File: rtl/updown_mod_counter_if.sv
// Control and status bundle of the up/down modulo counter; ovf/ovf_clr exist only with CNT_OVF_FLAG_EN.
// Pure wiring, so it adds no latency and has no flow control.
interface updown_mod_counter_if #(
    parameter int WIDTH = 3
);
    logic             enable;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] Q;
    logic             tc;
`ifdef CNT_OVF_FLAG_EN
    logic             ovf;
    logic             ovf_clr;

    modport master (output enable, up_dn, load, load_val, ovf_clr, input Q, tc, ovf);
    modport slave  (input enable, up_dn, load, load_val, ovf_clr, output Q, tc, ovf);
`else
    modport master (output enable, up_dn, load, load_val, input Q, tc);
    modport slave  (input enable, up_dn, load, load_val, output Q, tc);
`endif
endinterface

// File: rtl/updown_mod_counter_tff_cell.sv
// One storage bit of the counter: a T flip-flop with synchronous clear.
// Toggles on the edge after t is high; it has no flow control.
module tff_cell (
    input  logic clk,
    input  logic clear,
    input  logic t,
    output logic q
);

    always_ff @(posedge clk) begin
        if (clear) begin
            q <= 1'b0;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with load, wrap/saturate and cascadable tc; CNT_OVF_FLAG_EN adds a sticky ovf flag.
// Q updates one cycle after clear/load/enable, tc is combinational; it is always ready, with no backpressure.
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = 3,
    parameter int MODULUS  = 8,
    parameter int SATURATE = MODE_WRAP
) (
    input  logic                 clk,
    input  logic                 clear,
    updown_mod_counter_if.slave  bus
);

    if (MODULUS < 2 || cnt_clog2(MODULUS) > WIDTH) begin : g_bad_modulus
        $error("updown_mod_counter: MODULUS %0d illegal for WIDTH %0d", MODULUS, WIDTH);
    end

    localparam logic [WIDTH:0] MAX = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH:0]   q_ext;
    logic [WIDTH:0]   lv_ext;
    logic [WIDTH:0]   nxt_ext;
    logic             nxt_msb_unused;
    logic             at_top;
    logic             at_bot;
    logic             tc;

    // One bit of headroom lets the clamp compare load_val against MODULUS-1 even at MODULUS = 2**WIDTH.
    assign q_ext  = {1'b0, q};
    assign lv_ext = {1'b0, bus.load_val};
    assign at_top = (q_ext == MAX);
    assign at_bot = (q_ext == '0);
    assign tc     = bus.enable & ((bus.up_dn == DIR_UP) ? at_top : at_bot) & ~clear & ~bus.load;

    always_comb begin
        nxt_ext = q_ext;
        if (clear) begin
            nxt_ext = '0;
        end else if (bus.load) begin
            nxt_ext = (lv_ext > MAX) ? MAX : lv_ext;
        end else if (bus.enable) begin
            if (bus.up_dn == DIR_UP) begin
                if (!at_top) begin
                    nxt_ext = q_ext + ONE;
                end else if (SATURATE == MODE_WRAP) begin
                    nxt_ext = '0;
                end
            end else begin
                if (!at_bot) begin
                    nxt_ext = q_ext - ONE;
                end else if (SATURATE == MODE_WRAP) begin
                    nxt_ext = MAX;
                end
            end
        end
    end

    // The next value never exceeds MAX, so its top bit is always zero.
    assign nxt            = nxt_ext[WIDTH-1:0];
    assign nxt_msb_unused = nxt_ext[WIDTH];

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        tff_cell u_cell (
            .clk   (clk),
            .clear (clear),
            .t     (nxt[i] ^ q[i]),
            .q     (q[i])
        );
    end

    assign bus.Q  = q;
    assign bus.tc = tc;

`ifdef CNT_OVF_FLAG_EN
    logic ovf;

    // A new terminal event outranks a simultaneous ovf_clr so no overflow is lost.
    always_ff @(posedge clk) begin
        if (clear) begin
            ovf <= 1'b0;
        end else if (tc) begin
            ovf <= 1'b1;
        end else if (bus.ovf_clr) begin
            ovf <= 1'b0;
        end
    end

    assign bus.ovf = ovf;
`endif

endmodule

// File: tb/tb_updown_mod_counter.sv
// Scoreboard bench: mod-8 wrap, mod-5 wrap and mod-6 saturating counters share stimulus; a 2x mod-4 cascade runs alongside.
// Expected Q/ovf are pushed when inputs are driven and compared after the following edge.
module tb_updown_mod_counter;
    import counter_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clr, en, up, ld, oclr;
    logic [2:0] lv;
    logic       clrc, cen;

    updown_mod_counter_if #(.WIDTH(3)) b8 ();
    updown_mod_counter_if #(.WIDTH(3)) b5 ();
    updown_mod_counter_if #(.WIDTH(3)) b6 ();
    updown_mod_counter_if #(.WIDTH(2)) blo ();
    updown_mod_counter_if #(.WIDTH(2)) bhi ();

    assign b8.enable = en;  assign b8.up_dn = up;  assign b8.load = ld;  assign b8.load_val = lv;
    assign b5.enable = en;  assign b5.up_dn = up;  assign b5.load = ld;  assign b5.load_val = lv;
    assign b6.enable = en;  assign b6.up_dn = up;  assign b6.load = ld;  assign b6.load_val = lv;
    assign blo.enable = cen;    assign blo.up_dn = DIR_UP; assign blo.load = 1'b0; assign blo.load_val = 2'd0;
    assign bhi.enable = blo.tc; assign bhi.up_dn = DIR_UP; assign bhi.load = 1'b0; assign bhi.load_val = 2'd0;
`ifdef CNT_OVF_FLAG_EN
    assign b8.ovf_clr = oclr;  assign b5.ovf_clr = oclr;  assign b6.ovf_clr = oclr;
    assign blo.ovf_clr = 1'b0; assign bhi.ovf_clr = 1'b0;
`endif

    updown_mod_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(MODE_WRAP)) u_c8 (.clk(clk), .clear(clr), .bus(b8.slave));
    updown_mod_counter #(.WIDTH(3), .MODULUS(5), .SATURATE(MODE_WRAP)) u_c5 (.clk(clk), .clear(clr), .bus(b5.slave));
    updown_mod_counter #(.WIDTH(3), .MODULUS(6), .SATURATE(MODE_SAT))  u_c6 (.clk(clk), .clear(clr), .bus(b6.slave));
    updown_mod_counter #(.WIDTH(2), .MODULUS(4), .SATURATE(MODE_WRAP)) u_lo (.clk(clk), .clear(clrc), .bus(blo.slave));
    updown_mod_counter #(.WIDTH(2), .MODULUS(4), .SATURATE(MODE_WRAP)) u_hi (.clk(clk), .clear(clrc), .bus(bhi.slave));

    typedef struct { int dut; logic [31:0] exp; } sb_t;
    sb_t sbq[$];

    int  checks = 0;
    int  errors = 0;
    int  mq[3]   = '{0, 0, 0};
    bit  mo[3]   = '{1'b0, 1'b0, 1'b0};
    int  modv[3] = '{8, 5, 6};
    bit  satv[3] = '{1'b0, 1'b0, 1'b1};
    int  mc      = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] act(input int d);
        case (d)
            0:       return {29'd0, b8.Q};
            1:       return {29'd0, b5.Q};
            2:       return {29'd0, b6.Q};
            3:       return {28'd0, bhi.Q, blo.Q};
`ifdef CNT_OVF_FLAG_EN
            4:       return {31'd0, b8.ovf};
            5:       return {31'd0, b5.ovf};
            6:       return {31'd0, b6.ovf};
`endif
            default: return 32'hdead;
        endcase
    endfunction

    function automatic logic act_tc(input int k);
        case (k)
            0:       return b8.tc;
            1:       return b5.tc;
            default: return b6.tc;
        endcase
    endfunction

    function automatic int model_q(input int q, input bit c, input bit l, input int v,
                                   input bit e, input bit u, input int m, input bit sat);
        if (c) return 0;
        if (l) return (v >= m) ? m - 1 : v;
        if (!e) return q;
        if (u) return (q == m - 1) ? (sat ? q : 0) : q + 1;
        return (q == 0) ? (sat ? q : m - 1) : q - 1;
    endfunction

    task automatic cyc(input bit c, input bit l, input int v, input bit e, input bit u, input bit oc);
        sb_t s;
        bit  tce;
        clr = c; ld = l; lv = v[2:0]; en = e; up = u; oclr = oc;
        #1;
        for (int k = 0; k < 3; k++) begin
            tce = e && (u ? (mq[k] == modv[k] - 1) : (mq[k] == 0)) && !c && !l;
            chk($sformatf("tc_mod%0d", modv[k]), {31'd0, act_tc(k)}, {31'd0, tce});
            mq[k] = model_q(mq[k], c, l, v, e, u, modv[k], satv[k]);
            sbq.push_back('{k, mq[k]});
`ifdef CNT_OVF_FLAG_EN
            mo[k] = c ? 1'b0 : tce ? 1'b1 : oc ? 1'b0 : mo[k];
            sbq.push_back('{4 + k, {31'd0, mo[k]}});
`endif
        end
        tce = cen && (mc % 4 == 3) && !clrc;
        chk("tc_cascade_lo", {31'd0, blo.tc}, {31'd0, tce});
        mc = clrc ? 0 : cen ? (mc + 1) % 16 : mc;
        sbq.push_back('{3, mc});
        @(posedge clk);
        #1;
        while (sbq.size() > 0) begin
            s = sbq.pop_front();
            chk($sformatf("q_dut%0d", s.dut), act(s.dut), s.exp);
        end
    endtask

    initial begin
        clr = 1'b1; en = 1'b0; up = 1'b1; ld = 1'b0; lv = 3'd0; oclr = 1'b0;
        clrc = 1'b1; cen = 1'b0;

        // reset held two cycles, then free-running up count through a wrap
        repeat (2) cyc(1, 0, 0, 1, 1, 0);
        clrc = 1'b0;
        repeat (9) cyc(0, 0, 0, 1, 1, 0);

        // down count from 0: mod-5 gives 4,3,2,1,0,4
        cyc(1, 0, 0, 0, 1, 0);
        repeat (6) cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 1);

        // saturate: load 3 then up 4,5,5,5, then down to 4
        cyc(0, 1, 3, 1, 1, 0);
        repeat (4) cyc(0, 0, 0, 1, 1, 0);
        cyc(0, 0, 0, 1, 0, 0);

        // load priority over enable, clamp, clear over load
        cyc(0, 1, 2, 1, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 1, 7, 0, 1, 0);
        cyc(1, 1, 5, 1, 1, 0);

        // overflow flag: set, set-vs-clr, clr alone, clear
        cyc(0, 1, 7, 0, 1, 0);
        cyc(0, 0, 0, 1, 1, 0);
        cyc(0, 1, 7, 0, 1, 0);
        cyc(0, 0, 0, 1, 1, 1);
        cyc(0, 0, 0, 0, 1, 1);
        cyc(0, 1, 7, 0, 1, 0);
        cyc(0, 0, 0, 1, 1, 0);
        cyc(1, 0, 0, 0, 1, 0);

        // cascade: 0..15 and wrap
        cen = 1'b1;
        repeat (19) cyc(0, 0, 0, 0, 1, 0);
        cen = 1'b0;
        cyc(0, 0, 0, 0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/updown_mod_counter.md
# updown_mod_counter

Parametrised up/down modulo counter, the successor to the fixed 3-bit T-flip-flop counter. Adds configurable width and modulus, direction control, a synchronous parallel load, and a wrap or saturate mode. A terminal-count output lets instances cascade into wider counters. It is used as the general event and timebase counter in the lab designs.

## Interface
- `WIDTH`, default 3: count register width in bits.
- `MODULUS`, default 8: count range is 0..MODULUS-1. Legal range is 2 ≤ MODULUS ≤ 2**WIDTH.
- `SATURATE`, default 0: selects the terminal behaviour. 0 = wrap, 1 = hold at the terminal value.
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `clear`, input, 1: reset. Synchronous, active-high.
- `enable`, input, 1: count enable. The counter advances one step per cycle while high.
- `up_dn`, input, 1: direction. 1 = up, 0 = down.
- `load`, input, 1: synchronous parallel load strobe.
- `load_val`, input, WIDTH: value captured on `load`.
- `Q`, output, WIDTH: current count, registered.
- `tc`, output, 1: terminal count, combinational.
- `ovf`, output, 1: sticky overflow flag. Present only with `CNT_OVF_FLAG_EN`.
- `ovf_clr`, input, 1: clears `ovf`. Present only with `CNT_OVF_FLAG_EN`.

## Operation
- Priority order on each rising edge: `clear` > `load` > `enable` > hold.
- `clear`:
  - `Q` goes to 0 on the next edge.
  - `ovf` goes to 0.
  - All other inputs are ignored that cycle.
- `load`:
  - `Q` takes `load_val` on the next edge, regardless of `enable`.
  - If `load_val` ≥ MODULUS, `Q` takes MODULUS-1 (clamped).
- Counting up (`enable`=1, `up_dn`=1):
  - `Q` < MODULUS-1: `Q` becomes `Q`+1.
  - `Q` = MODULUS-1 and SATURATE=0: `Q` becomes 0.
  - `Q` = MODULUS-1 and SATURATE=1: `Q` holds.
- Counting down (`enable`=1, `up_dn`=0):
  - `Q` > 0: `Q` becomes `Q`-1.
  - `Q` = 0 and SATURATE=0: `Q` becomes MODULUS-1.
  - `Q` = 0 and SATURATE=1: `Q` holds.
- `tc` = `enable` & (`up_dn` ? `Q`==MODULUS-1 : `Q`==0) & ~`clear` & ~`load`.
  - `tc` marks the cycle in which a wrap or saturate event occurs at the next edge.
  - For cascading, connect the lower stage's `tc` to the upper stage's `enable`.
- A direction change takes effect on the same edge; there is no turnaround penalty.
- Arithmetic is performed at WIDTH+1 bits internally. `Q` never leaves 0..MODULUS-1.
- A non-power-of-two MODULUS is fully supported. With MODULUS = 2**WIDTH, the counter behaves as a natural binary wrap.

## Timing
- All outputs are registered except `tc`.
- Reset values: `Q`=0 and `ovf`=0. `tc` follows its equation, which gives 0 while `clear`=1.
- Latency from `enable`, `load` or `clear` to a change in `Q` is one cycle.
- `tc` is valid in the same cycle as its inputs. It has a combinational path from `enable`, `up_dn`, `load` and `clear`.
- A `clear` issued in the middle of a count overrides an in-flight load or count in that cycle. Counting resumes from 0 on the first cycle after `clear` deasserts.

## Configuration
- Macro: `CNT_OVF_FLAG_EN`.
- Defined:
  - The `ovf` output and `ovf_clr` input exist.
  - `ovf` sets on any edge where `tc`=1, which covers both wrap and saturate attempts.
  - `ovf` clears on `clear`, or on `ovf_clr`.
  - If set and `ovf_clr` occur in the same cycle, set wins.
  - `ovf` stays high until it is cleared.
- Undefined: neither port exists, and there is no flag logic. All other behaviour is identical.

## Structure
- Package `counter_pkg` holds:
  - `DIR_UP`=1'b1 and `DIR_DN`=1'b0.
  - `MODE_WRAP`=0 and `MODE_SAT`=1.
  - A `clog2`-style helper function for checking MODULUS.
- Sub-module `tff_cell` provides the per-bit storage:
  - It is a T flip-flop with synchronous clear.
  - Its T input is driven by (next_state[i] ^ Q[i]), so storage stays in the T flip-flop family.
- Parameter legality is checked at elaboration. If MODULUS < 2 or MODULUS > 2**WIDTH, elaboration stops with `$error`.

## Test plan
- **Reset:** WIDTH=3, MODULUS=8, with `clear`=1 for 2 cycles and then released with `enable`=1 and `up_dn`=1. Required: `Q`=0 during `clear`, then 1, 2, …, 7, 0. `tc`=1 exactly when `Q`=7.
- **Modulo-5 down count:** MODULUS=5, `up_dn`=0, starting from `Q`=0. Required: `Q` sequence 4, 3, 2, 1, 0, 4. `tc` high while `Q`=0.
- **Saturate:** SATURATE=1, MODULUS=6, counting up from a load of 3. Required: 4, 5, 5, 5. Switching to `up_dn`=0 then gives 4 on the next edge.
- **Load priority and clamp:**
  - `load`=1 with `load_val`=2 while `enable`=1: required `Q`=2 next cycle with no increment.
  - `load_val`=7 with MODULUS=5: required `Q`=4.
  - `load` and `clear` together: required `Q`=0.
- **Overflow flag (`CNT_OVF_FLAG_EN` defined):** wrap 7→0. Required: `ovf`=1 on the edge after `tc`.
  - `ovf_clr` asserted in the same cycle as a new `tc`: `ovf` stays 1.
  - `ovf_clr` alone: `ovf`=0.
  - `clear`: `ovf`=0.
- **Cascade:** two instances with WIDTH=2 and MODULUS=4, where the low stage's `tc` drives the high stage's `enable`. Required: the combined value counts 0..15 and wraps. The high stage increments exactly when the low stage goes 3→0.
